// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write-side loader for the CPU's instruction memory. A host (typically a UART
// receiver) streams bytes in over a valid/ready handshake. The loader reads a
// 2-byte word-count header and then assembles N 16-bit instruction words. It
// writes them to the instruction memory at sequential addresses starting at 0,
// and holds the CPU frozen until the whole program has been written.
//
// Stream format (high byte always first):
//   N[15:8], N[7:0], W0[15:8], W0[7:0], W1[15:8], W1[7:0], ...
//
// Handshake: a byte moves only on a rising clk edge where in_valid && in_ready.
//   - in_ready depends only on the FSM state, never on in_valid.
//   - in_byte is ignored whenever in_ready is low.
//   - in_valid may stay low for any length of time; there is no timeout.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle pulse; begins a load from IDLE or DONE only
//   in_valid     byte-stream valid
//   in_byte      byte-stream data
//   in_ready     loader can take a byte this cycle
//   IM_we        instruction memory write enable, one-cycle pulse per word
//   IM_waddr     instruction memory write address
//   IM_wdata     instruction memory write data
//   cpu_hold     1 = CPU PC/pipeline frozen
//   done         load finished successfully (level)
//   err          header rejected (level)
//   o_dbg_state  current FSM state, for debug and checkers
//
// Supported parameter range: DATA_W = 16, and 8 <= ADDR_W <= 14. With these
// limits the internal count width (ADDR_W+1) fits inside the 16-bit header.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              IM_we,
    output logic [ADDR_W-1:0] IM_waddr,
    output logic [DATA_W-1:0] IM_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [2:0]        o_dbg_state
);

    // Word count and written count are one bit wider than the address. This
    // lets a full-depth load (N = 2^ADDR_W) be represented exactly.
    localparam int CNT_W   = ADDR_W + 1;
    // Number of header high-byte bits that land inside the internal count.
    // The remaining upper bits only matter as an overflow flag.
    localparam int HI_KEEP = CNT_W - 8;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_CHECK  = 3'd3,
        S_DAT_HI = 3'd4,
        S_DAT_LO = 3'd5,
        S_WRITE  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;        // N, low CNT_W bits
    logic                r_cnt_ovf;    // header bits above CNT_W were nonzero
    logic [CNT_W-1:0]    r_written;    // words written so far in this load
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_done;
    logic                r_err;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t              w_state_nxt;
    logic                w_in_ready;
    logic                w_we;
    logic                w_accept;
    logic                w_start_ok;
    logic                w_hdr_bad;
    logic [CNT_W-1:0]    w_written_inc;
    logic                w_last;

    assign w_accept      = w_in_ready & in_valid;
    assign w_start_ok    = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_hdr_bad     = r_cnt_ovf | (r_cnt == '0) | (r_cnt > DEPTH);
    assign w_written_inc = r_written + CNT_W'(1);
    // The word being written in WRITE is the final one of the load.
    assign w_last        = (w_written_inc == r_cnt);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nxt = w_hdr_bad ? S_DONE : S_DAT_HI;
            end
            S_DAT_HI: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_DAT_LO;
                end
            end
            S_DAT_LO: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_we        = 1'b1;
                w_state_nxt = w_last ? S_DONE : S_DAT_HI;
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_CNT_HI;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: header, assembly buffer, address and status flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_cnt_ovf <= 1'b0;
            r_written <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // A new load wipes the status of the previous one.
            if (w_start_ok) begin
                r_cnt     <= '0;
                r_cnt_ovf <= 1'b0;
                r_written <= '0;
                r_waddr   <= '0;
                r_done    <= 1'b0;
                r_err     <= 1'b0;
            end

            case (r_state)
                S_CNT_HI: begin
                    if (w_accept) begin
                        r_cnt[CNT_W-1:8] <= in_byte[HI_KEEP-1:0];
                        r_cnt_ovf        <= |in_byte[7:HI_KEEP];
                    end
                end
                S_CNT_LO: begin
                    if (w_accept) begin
                        r_cnt[7:0] <= in_byte;
                    end
                end
                S_CHECK: begin
                    if (w_hdr_bad) begin
                        r_err <= 1'b1;
                    end
                end
                S_DAT_HI: begin
                    if (w_accept) begin
                        r_wdata[15:8] <= in_byte;
                    end
                end
                S_DAT_LO: begin
                    if (w_accept) begin
                        r_wdata[7:0] <= in_byte;
                    end
                end
                S_WRITE: begin
                    r_written <= w_written_inc;
                    // On the last word the address stays put. A full-depth
                    // load therefore ends at 2^ADDR_W-1 and never wraps to 0.
                    if (w_last) begin
                        r_done <= 1'b1;
                    end else begin
                        r_waddr <= r_waddr + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready    = w_in_ready;
    assign IM_we       = w_we;
    assign IM_waddr    = r_waddr;
    assign IM_wdata    = r_wdata;
    // The CPU is released only by a successful load. A rejected header keeps
    // it frozen.
    assign cpu_hold    = ~r_done;
    assign done        = r_done;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule
